// File: rtl/serial_logic_unit_pkg.sv
// Shared ALU definitions: opcodes (also used by the combinational ALU),
// serial-unit state encodings and the default datapath width.
package serial_logic_unit_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_NAND  = 3'b011,
    OP_NOR   = 3'b100,
    OP_XNOR  = 3'b101,
    OP_NOTA  = 3'b110,
    OP_PASSA = 3'b111
  } op_e;

  // Bit 0 of the state is busy and bit 1 is done, so both outputs come straight off the state flops.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

endpackage

// File: rtl/serial_logic_unit_if.sv
// Request/result bundle of the serial logic unit.
// Handshake: start is sampled only while the unit is not busy (IDLE or DONE); done is a one-cycle pulse marking a fresh res/zero.
interface serial_logic_unit_if #(
  parameter int WIDTH = serial_logic_unit_pkg::DEFAULT_WIDTH
);
  logic                        start;
  serial_logic_unit_pkg::op_e  op;
  logic [WIDTH-1:0]            a;
  logic [WIDTH-1:0]            b;
  logic                        busy;
  logic                        done;
  logic [WIDTH-1:0]            res;
  logic                        zero;

  modport master (output start, op, a, b, input busy, done, res, zero);
  modport slave  (input start, op, a, b, output busy, done, res, zero);
endinterface

// File: rtl/serial_logic_unit_logic_slice.sv
// Combinational SLICE-bit bitwise op mux; bit i of y depends only on bit i of a and b.
module serial_logic_unit_logic_slice
  import serial_logic_unit_pkg::*;
#(
  parameter int SLICE = 1
) (
  input  op_e              i_op,
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  output logic [SLICE-1:0] o_y
);

  always_comb begin
    o_y = i_a;
    case (i_op)
      OP_AND:   o_y = i_a & i_b;
      OP_OR:    o_y = i_a | i_b;
      OP_XOR:   o_y = i_a ^ i_b;
      OP_NAND:  o_y = ~(i_a & i_b);
      OP_NOR:   o_y = ~(i_a | i_b);
      OP_XNOR:  o_y = ~(i_a ^ i_b);
      OP_NOTA:  o_y = ~i_a;
      OP_PASSA: o_y = i_a;
      default:  o_y = i_a;
    endcase
  end

endmodule

// File: rtl/serial_logic_unit.sv
// Bit-serial bitwise logic unit: latches a/b/op on start, processes SLICE bits per clock,
// pulses done and holds res/zero until the next completion.
module serial_logic_unit
  import serial_logic_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_logic_unit_if.slave   bus,
  output logic [1:0]           o_dbg_state
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("serial_logic_unit: SLICE must divide WIDTH");
  end

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  op_e              r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;

  logic [SLICE-1:0] w_y;
  logic [WIDTH-1:0] w_acc_next;

  serial_logic_unit_logic_slice #(.SLICE(SLICE)) u_slice (
    .i_op (r_op),
    .i_a  (r_a[SLICE-1:0]),
    .i_b  (r_b[SLICE-1:0]),
    .o_y  (w_y)
  );

  // New bits enter at the MSB end, so after N slices bit i of the accumulator lines up with bit i of the operands.
  if (SLICE == WIDTH) begin : g_acc_full
    assign w_acc_next = w_y;
  end else begin : g_acc_shift
    assign w_acc_next = {w_y, r_acc[WIDTH-1:SLICE]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_op    <= OP_AND;
      r_cnt   <= '0;
      r_res   <= '0;
      r_zero  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_op    <= bus.op;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> SLICE;
          r_b   <= r_b >> SLICE;
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_res   <= w_acc_next;
            r_zero  <= (w_acc_next == '0);
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = r_state[0];
  assign bus.done    = r_state[1];
  assign bus.res     = r_res;
  assign bus.zero    = r_zero;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed bench for serial_logic_unit: a SLICE=1 and a SLICE=4 instance, vector table plus multi-cycle sequences.
module tb_serial_logic_unit;
  import serial_logic_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_logic_unit_if #(.WIDTH(32)) bus1 ();
  serial_logic_unit_if #(.WIDTH(32)) bus4 ();
  logic [1:0] dbg1;
  logic [1:0] dbg4;

  serial_logic_unit #(.WIDTH(32), .SLICE(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .o_dbg_state(dbg1)
  );
  serial_logic_unit #(.WIDTH(32), .SLICE(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4), .o_dbg_state(dbg4)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_busy(input int s);
    return (s == 4) ? bus4.busy : bus1.busy;
  endfunction

  function automatic logic get_done(input int s);
    return (s == 4) ? bus4.done : bus1.done;
  endfunction

  // ---------------- driver tasks ----------------
  // Returns #1 after the edge that samples start.
  task automatic start_op(input int s, input op_e op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if (s == 4) begin
      bus4.start = 1'b1; bus4.op = op; bus4.a = a; bus4.b = b;
    end else begin
      bus1.start = 1'b1; bus1.op = op; bus1.a = a; bus1.b = b;
    end
    @(posedge clk);
    #1;
    if (s == 4) bus4.start = 1'b0;
    else        bus1.start = 1'b0;
  endtask

  // lat = edges after the sampling edge at which done is seen; -1 on timeout.
  task automatic wait_done(input int s, input int limit, output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int c = 0; c <= limit; c++) begin
      if (get_busy(s)) bcnt++;
      if (get_done(s)) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int bcnt;
    int early;
    int ndone;

    vecs[0]  = '{OP_AND,   32'h0000_000B, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[1]  = '{OP_AND,   32'hF0F0_1234, 32'hFF00_00FF, 32'hF000_0034, 1'b0};
    vecs[2]  = '{OP_OR,    32'hF0F0_1234, 32'hFF00_00FF, 32'hFFF0_12FF, 1'b0};
    vecs[3]  = '{OP_XOR,   32'hF0F0_1234, 32'hFF00_00FF, 32'h0FF0_12CB, 1'b0};
    vecs[4]  = '{OP_NAND,  32'hF0F0_1234, 32'hFF00_00FF, 32'h0FFF_FFCB, 1'b0};
    vecs[5]  = '{OP_NOR,   32'hF0F0_1234, 32'hFF00_00FF, 32'h000F_ED00, 1'b0};
    vecs[6]  = '{OP_XNOR,  32'hF0F0_1234, 32'hFF00_00FF, 32'hF00F_ED34, 1'b0};
    vecs[7]  = '{OP_NOTA,  32'hF0F0_1234, 32'hFF00_00FF, 32'h0F0F_EDCB, 1'b0};
    vecs[8]  = '{OP_PASSA, 32'hF0F0_1234, 32'hFF00_00FF, 32'hF0F0_1234, 1'b0};
    vecs[9]  = '{OP_PASSA, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[10] = '{OP_XNOR,  32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0};

    bus1.start = 1'b0; bus1.op = OP_AND; bus1.a = '0; bus1.b = '0;
    bus4.start = 1'b0; bus4.op = OP_AND; bus4.a = '0; bus4.b = '0;

    // ---------------- reset state ----------------
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, bus1.busy}, 32'd0);
    chk("rst_done", {31'b0, bus1.done}, 32'd0);
    chk("rst_res",  bus1.res, 32'd0);
    chk("rst_zero", {31'b0, bus1.zero}, 32'd1);
    chk("rst_res4", bus4.res, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // ---------------- vector table, SLICE=1 ----------------
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].res);
      start_op(1, vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(1, 40, lat, bcnt);
      chk($sformatf("v%0d_latency", i), lat, 32'd32);
      chk($sformatf("v%0d_busy_cycles", i), bcnt, 32'd32);
      chk($sformatf("v%0d_res", i), bus1.res, exp_q.pop_front());
      chk($sformatf("v%0d_zero", i), {31'b0, bus1.zero}, {31'b0, vecs[i].zero});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_width", i), {31'b0, bus1.done}, 32'd0);
    end

    // ---------------- reset mid-RUN ----------------
    start_op(1, OP_AND, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(posedge clk);
    #1;
    chk("pre_reset_busy", {31'b0, bus1.busy}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_busy", {31'b0, bus1.busy}, 32'd0);
    chk("async_rst_done", {31'b0, bus1.done}, 32'd0);
    chk("async_rst_res",  bus1.res, 32'd0);
    chk("async_rst_zero", {31'b0, bus1.zero}, 32'd1);
    chk("async_rst_state", {30'b0, dbg1}, {30'b0, S_IDLE});
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus1.done) ndone++;
    end
    chk("no_done_after_reset", ndone, 32'd0);

    // ---------------- start during RUN is ignored ----------------
    start_op(1, OP_OR, 32'h1234_0000, 32'h0000_5678);
    lat   = -1;
    early = 0;
    for (int c = 0; c <= 40; c++) begin
      if (bus1.done) begin
        lat = c;
        break;
      end
      if (bus1.res !== 32'h0) early++;
      bus1.start = (c == 5);
      if (c == 5) begin
        bus1.op = OP_AND; bus1.a = '1; bus1.b = '1;
      end
      @(posedge clk);
      #1;
    end
    bus1.start = 1'b0;
    chk("ign_latency", lat, 32'd32);
    chk("ign_res_held", early, 32'd0);
    chk("ign_res", bus1.res, 32'h1234_5678);
    @(posedge clk);
    #1;
    chk("ign_not_queued", {30'b0, dbg1}, {30'b0, S_IDLE});

    // ---------------- start held through DONE ----------------
    @(negedge clk);
    bus1.start = 1'b1; bus1.op = OP_XOR; bus1.a = 32'hAAAA_5555; bus1.b = 32'hFFFF_0000;
    @(posedge clk);
    #1;
    wait_done(1, 40, lat, bcnt);
    chk("b2b_lat1", lat, 32'd32);
    chk("b2b_state_done", {30'b0, dbg1}, {30'b0, S_DONE});
    chk("b2b_res1", bus1.res, 32'h5555_5555);
    bus1.op = OP_NOR; bus1.a = '0; bus1.b = '0;
    @(posedge clk);
    #1;
    chk("b2b_done_width", {31'b0, bus1.done}, 32'd0);
    chk("b2b_no_idle", {30'b0, dbg1}, {30'b0, S_RUN});
    bus1.start = 1'b0;
    // Second pulse is 33 edges after the first: 32 non-done cycles between them.
    wait_done(1, 40, lat, bcnt);
    chk("b2b_lat2", lat, 32'd32);
    chk("b2b_res2", bus1.res, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    chk("b2b_done2_width", {31'b0, bus1.done}, 32'd0);

    // ---------------- SLICE=4 instance ----------------
    start_op(4, OP_AND, 32'hF0F0_1234, 32'hFF00_00FF);
    wait_done(4, 20, lat, bcnt);
    chk("s4_and_latency", lat, 32'd8);
    chk("s4_and_res", bus4.res, 32'hF000_0034);
    chk("s4_and_zero", {31'b0, bus4.zero}, 32'd0);
    start_op(4, OP_XOR, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(4, 20, lat, bcnt);
    chk("s4_xor_latency", lat, 32'd8);
    chk("s4_xor_busy_cycles", bcnt, 32'd8);
    chk("s4_xor_res", bus4.res, 32'h0);
    chk("s4_xor_zero", {31'b0, bus4.zero}, 32'd1);
    @(posedge clk);
    #1;
    chk("s4_done_width", {31'b0, bus4.done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
